// File: rtl/roi_pkg.sv
// Shared types and helpers for the ROI-to-APB register writer.
package roi_pkg;

    localparam int unsigned MAX_HALF_W = 32;

    localparam logic ADDR_XY0 = 1'b0;
    localparam logic ADDR_XY1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_NEXT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } roi_state_e;

    // Place y above x; half_w is the coordinate width used by the caller.
    function automatic logic [2*MAX_HALF_W-1:0] pack_xy(
        input logic [MAX_HALF_W-1:0] y,
        input logic [MAX_HALF_W-1:0] x,
        input int unsigned           half_w
    );
        return ((2*MAX_HALF_W)'(y) << half_w) | (2*MAX_HALF_W)'(x);
    endfunction

endpackage

// File: rtl/roi_apb_master.sv
// Accepts an ROI command, validates it and writes both corner words over APB.
module roi_apb_master
    import roi_pkg::*;
#(
    parameter int unsigned WIDTH   = 800,
    parameter int unsigned HEIGHT  = 600,
    parameter int unsigned BIT_C   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [BIT_C/2-1:0] cmd_x0_i,
    input  logic [BIT_C/2-1:0] cmd_y0_i,
    input  logic [BIT_C/2-1:0] cmd_x1_i,
    input  logic [BIT_C/2-1:0] cmd_y1_i,
    output logic               apb_psel_o,
    output logic               apb_penable_o,
    output logic               apb_pwrite_o,
    output logic               apb_paddr_o,
    output logic [BIT_C-1:0]   apb_pwdata_o,
    input  logic               apb_pready_i,
    input  logic               apb_pslverr_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int unsigned HALF_W = BIT_C / 2;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    roi_state_e         state_q, state_d;
    logic               idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [HALF_W-1:0]  x0_q, y0_q, x1_q, y1_q;
    logic [HALF_W-1:0]  x0_d, y0_d, x1_d, y1_d;

    logic               ready_d, psel_d, penable_d, pwrite_d, paddr_d;
    logic [BIT_C-1:0]   pwdata_d;
    logic               busy_d, done_d, err_d;

    logic               cmd_ok_c;
    logic [BIT_C-1:0]   word0_in_c, word1_reg_c;

    assign cmd_ok_c = (cmd_x0_i <= cmd_x1_i) && (cmd_y0_i <= cmd_y1_i) &&
                      (cmd_x1_i < HALF_W'(WIDTH)) && (cmd_y1_i < HALF_W'(HEIGHT));

    // Word 0 is launched from the command inputs, word 1 from the captured corners.
    assign word0_in_c  = BIT_C'(pack_xy(MAX_HALF_W'(cmd_y0_i), MAX_HALF_W'(cmd_x0_i), HALF_W));
    assign word1_reg_c = BIT_C'(pack_xy(MAX_HALF_W'(y1_q), MAX_HALF_W'(x1_q), HALF_W));

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        ready_d   = 1'b0;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        paddr_d   = 1'b0;
        pwdata_d  = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    x0_d = cmd_x0_i;
                    y0_d = cmd_y0_i;
                    x1_d = cmd_x1_i;
                    y1_d = cmd_y1_i;
                    if (cmd_ok_c) begin
                        state_d  = ST_SETUP;
                        idx_d    = 1'b0;
                        wait_d   = '0;
                        psel_d   = 1'b1;
                        pwrite_d = 1'b1;
                        paddr_d  = ADDR_XY0;
                        pwdata_d = word0_in_c;
                        busy_d   = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                pwrite_d  = 1'b1;
                paddr_d   = apb_paddr_o;
                pwdata_d  = apb_pwdata_o;
                busy_d    = 1'b1;
            end
            ST_ACCESS: begin
                if (apb_pready_i) begin
                    if (apb_pslverr_i) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (idx_q == 1'b0) begin
                        state_d = ST_NEXT;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_d    = wait_q + WAIT_W'(1);
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    pwrite_d  = 1'b1;
                    paddr_d   = apb_paddr_o;
                    pwdata_d  = apb_pwdata_o;
                    busy_d    = 1'b1;
                end
            end
            ST_NEXT: begin
                state_d  = ST_SETUP;
                idx_d    = 1'b1;
                wait_d   = '0;
                psel_d   = 1'b1;
                pwrite_d = 1'b1;
                paddr_d  = ADDR_XY1;
                pwdata_d = word1_reg_c;
                busy_d   = 1'b1;
            end
            ST_DONE, ST_ERR: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q       <= ST_IDLE;
            idx_q         <= 1'b0;
            wait_q        <= '0;
            x0_q          <= '0;
            y0_q          <= '0;
            x1_q          <= '0;
            y1_q          <= '0;
            cmd_ready_o   <= 1'b1;
            apb_psel_o    <= 1'b0;
            apb_penable_o <= 1'b0;
            apb_pwrite_o  <= 1'b0;
            apb_paddr_o   <= 1'b0;
            apb_pwdata_o  <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wait_q        <= wait_d;
            x0_q          <= x0_d;
            y0_q          <= y0_d;
            x1_q          <= x1_d;
            y1_q          <= y1_d;
            cmd_ready_o   <= ready_d;
            apb_psel_o    <= psel_d;
            apb_penable_o <= penable_d;
            apb_pwrite_o  <= pwrite_d;
            apb_paddr_o   <= paddr_d;
            apb_pwdata_o  <= pwdata_d;
            busy_o        <= busy_d;
            done_o        <= done_d;
            err_o         <= err_d;
        end
    end

endmodule

// File: tb/tb_roi_apb_master.sv
// Directed bench for roi_apb_master with a scripted APB completer.
module tb_roi_apb_master;

    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [15:0] cmd_x0_i = '0, cmd_y0_i = '0, cmd_x1_i = '0, cmd_y1_i = '0;
    logic        apb_psel_o, apb_penable_o, apb_pwrite_o, apb_paddr_o;
    logic [31:0] apb_pwdata_o;
    logic        apb_pready_i = 1'b1;
    logic        apb_pslverr_i = 1'b1;
    logic        busy_o, done_o, err_o;

    int asserts = 0;
    int failures = 0;

    roi_apb_master dut (
        .clk_i         (clk_i),
        .arst_ni       (arst_ni),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_x0_i      (cmd_x0_i),
        .cmd_y0_i      (cmd_y0_i),
        .cmd_x1_i      (cmd_x1_i),
        .cmd_y1_i      (cmd_y1_i),
        .apb_psel_o    (apb_psel_o),
        .apb_penable_o (apb_penable_o),
        .apb_pwrite_o  (apb_pwrite_o),
        .apb_paddr_o   (apb_paddr_o),
        .apb_pwdata_o  (apb_pwdata_o),
        .apb_pready_i  (apb_pready_i),
        .apb_pslverr_i (apb_pslverr_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Offer a command at a negedge once ready; returns just after the accepting edge.
    task automatic issue(input logic [15:0] x0, input logic [15:0] y0,
                         input logic [15:0] x1, input logic [15:0] y1, output bit acc);
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk_i);
            if (cmd_ready_o === 1'b1) acc = 1'b1;
        end
        if (acc) begin
            cmd_x0_i = x0; cmd_y0_i = y0; cmd_x1_i = x1; cmd_y1_i = y1;
            cmd_valid_i = 1'b1;
            @(posedge clk_i);
            #1;
            cmd_valid_i = 1'b0;
        end
    endtask

    // Plays the completer and records what the requester did, cycle by cycle after accept.
    task automatic watch(input int max_cyc, input int stall0, input bit err0, input bit stuck,
                         output int done_cyc, output int err_cyc, output int nxfer,
                         output logic addr0, output logic [31:0] data0,
                         output logic addr1, output logic [31:0] data1,
                         output int unstable, output int proto_bad, output int nacc,
                         output logic busy_at_end, output int psel_cnt);
        logic cur_addr;
        logic [31:0] cur_data;
        int stall;
        done_cyc = -1; err_cyc = -1; nxfer = 0; unstable = 0; proto_bad = 0;
        nacc = 0; psel_cnt = 0; stall = 0; busy_at_end = 1'bx;
        addr0 = 1'bx; addr1 = 1'bx; data0 = 'x; data1 = 'x;
        cur_addr = 1'b0; cur_data = '0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk_i);
            if (apb_psel_o !== 1'b1 && (apb_penable_o !== 1'b0 || apb_pwrite_o !== 1'b0))
                proto_bad++;
            if (cmd_ready_o === 1'b1 && busy_o === 1'b1) proto_bad++;
            if (apb_psel_o === 1'b1) psel_cnt++;
            if (apb_psel_o === 1'b1 && apb_penable_o === 1'b0) begin
                cur_addr = apb_paddr_o;
                cur_data = apb_pwdata_o;
                if (nxfer == 0) begin addr0 = cur_addr; data0 = cur_data; end
                else begin addr1 = cur_addr; data1 = cur_data; end
                nxfer++;
                stall = 0;
                apb_pready_i = 1'b1; apb_pslverr_i = 1'b1;
            end else if (apb_psel_o === 1'b1 && apb_penable_o === 1'b1) begin
                nacc++;
                if (apb_paddr_o !== cur_addr || apb_pwdata_o !== cur_data || apb_pwrite_o !== 1'b1)
                    unstable++;
                apb_pslverr_i = 1'b0;
                if (stuck) apb_pready_i = 1'b0;
                else if (nxfer == 1 && stall < stall0) begin
                    apb_pready_i = 1'b0; stall++;
                end else begin
                    apb_pready_i = 1'b1;
                    apb_pslverr_i = err0 && (nxfer == 1);
                end
            end else begin
                // Response lines are driven active outside ACCESS; the requester must ignore them.
                apb_pready_i = 1'b1; apb_pslverr_i = 1'b1;
            end
            if (done_o === 1'b1 && done_cyc < 0) begin done_cyc = c; busy_at_end = busy_o; end
            if (err_o === 1'b1 && err_cyc < 0) begin err_cyc = c; busy_at_end = busy_o; end
            if (done_cyc > 0 || err_cyc > 0) break;
        end
        apb_pready_i = 1'b1; apb_pslverr_i = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        asserts++;
        if ({apb_psel_o, apb_penable_o, apb_pwrite_o, apb_paddr_o, busy_o, done_o, err_o} !== 7'b0 ||
            apb_pwdata_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: got psel=%b pen=%b pwr=%b paddr=%b pwdata=%h busy=%b done=%b err=%b, expected all zero",
                     apb_psel_o, apb_penable_o, apb_pwrite_o, apb_paddr_o, apb_pwdata_o, busy_o, done_o, err_o);
        end
        #20 arst_ni = 1'b1;
        @(negedge clk_i);
        asserts++;
        if (cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", cmd_ready_o);
        end
    endtask

    task automatic test_basic();
        bit acc;
        int dc, ec, nx, un, pb, na, ps;
        logic a0, a1, bz;
        logic [31:0] d0, d1;
        issue(16'd10, 16'd20, 16'd100, 16'd200, acc);
        asserts++;
        if (!acc) begin failures++; $display("FAIL basic_accept: got 0 expected 1"); end
        watch(40, 0, 1'b0, 1'b0, dc, ec, nx, a0, d0, a1, d1, un, pb, na, bz, ps);
        asserts++;
        if (dc !== 6 || ec !== -1) begin
            failures++; $display("FAIL basic_latency: got done=%0d err=%0d expected done=6 err=-1", dc, ec);
        end
        asserts++;
        if (nx !== 2 || a0 !== 1'b0 || d0 !== 32'h0014000A || a1 !== 1'b1 || d1 !== 32'h00C80064) begin
            failures++;
            $display("FAIL basic_writes: got n=%0d %b:%h %b:%h expected 2 0:0014000a 1:00c80064", nx, a0, d0, a1, d1);
        end
        asserts++;
        if (pb !== 0 || un !== 0) begin
            failures++; $display("FAIL basic_protocol: got bad=%0d unstable=%0d expected 0 0", pb, un);
        end
    endtask

    task automatic test_wait();
        bit acc;
        int dc, ec, nx, un, pb, na, ps;
        logic a0, a1, bz;
        logic [31:0] d0, d1;
        issue(16'd10, 16'd20, 16'd100, 16'd200, acc);
        watch(40, 3, 1'b0, 1'b0, dc, ec, nx, a0, d0, a1, d1, un, pb, na, bz, ps);
        asserts++;
        if (dc !== 9) begin failures++; $display("FAIL wait_latency: got %0d expected 9", dc); end
        asserts++;
        if (un !== 0 || na !== 5) begin
            failures++; $display("FAIL wait_stable: got unstable=%0d access=%0d expected 0 5", un, na);
        end
        asserts++;
        if (d1 !== 32'h00C80064) begin failures++; $display("FAIL wait_data1: got %h expected 00c80064", d1); end
    endtask

    task automatic test_invalid();
        bit acc;
        int dc, ec, nx, un, pb, na, ps;
        logic a0, a1, bz;
        logic [31:0] d0, d1;
        issue(16'd0, 16'd0, 16'd800, 16'd10, acc);
        watch(20, 0, 1'b0, 1'b0, dc, ec, nx, a0, d0, a1, d1, un, pb, na, bz, ps);
        asserts++;
        if (ec !== 1 || ps !== 0) begin
            failures++; $display("FAIL invalid_x1: got err=%0d psel_cycles=%0d expected 1 0", ec, ps);
        end
        issue(16'd50, 16'd0, 16'd40, 16'd10, acc);
        watch(20, 0, 1'b0, 1'b0, dc, ec, nx, a0, d0, a1, d1, un, pb, na, bz, ps);
        asserts++;
        if (ec !== 1 || ps !== 0 || dc !== -1) begin
            failures++; $display("FAIL invalid_order: got err=%0d psel=%0d done=%0d expected 1 0 -1", ec, ps, dc);
        end
        issue(16'd799, 16'd599, 16'd799, 16'd599, acc);
        watch(20, 0, 1'b0, 1'b0, dc, ec, nx, a0, d0, a1, d1, un, pb, na, bz, ps);
        asserts++;
        if (dc !== 6 || d0 !== 32'h0257031F) begin
            failures++; $display("FAIL corner_max: got done=%0d data0=%h expected 6 0257031f", dc, d0);
        end
    endtask

    task automatic test_slverr();
        bit acc;
        int dc, ec, nx, un, pb, na, ps;
        logic a0, a1, bz;
        logic [31:0] d0, d1;
        issue(16'd1, 16'd2, 16'd3, 16'd4, acc);
        watch(20, 0, 1'b1, 1'b0, dc, ec, nx, a0, d0, a1, d1, un, pb, na, bz, ps);
        asserts++;
        if (ec !== 3 || nx !== 1 || dc !== -1) begin
            failures++; $display("FAIL slverr_abort: got err=%0d xfers=%0d done=%0d expected 3 1 -1", ec, nx, dc);
        end
        asserts++;
        if (bz !== 1'b0) begin failures++; $display("FAIL slverr_busy: got %b expected 0", bz); end
    endtask

    task automatic test_timeout();
        bit acc;
        int dc, ec, nx, un, pb, na, ps;
        logic a0, a1, bz;
        logic [31:0] d0, d1;
        issue(16'd5, 16'd6, 16'd7, 16'd8, acc);
        watch(40, 0, 1'b0, 1'b1, dc, ec, nx, a0, d0, a1, d1, un, pb, na, bz, ps);
        asserts++;
        if (na !== 16 || ec !== 18) begin
            failures++; $display("FAIL timeout_len: got access=%0d err=%0d expected 16 18", na, ec);
        end
        asserts++;
        if (apb_psel_o !== 1'b0 || apb_penable_o !== 1'b0) begin
            failures++; $display("FAIL timeout_drop: got psel=%b pen=%b expected 0 0", apb_psel_o, apb_penable_o);
        end
        issue(16'd10, 16'd20, 16'd100, 16'd200, acc);
        watch(40, 0, 1'b0, 1'b0, dc, ec, nx, a0, d0, a1, d1, un, pb, na, bz, ps);
        asserts++;
        if (!acc || dc !== 6) begin
            failures++; $display("FAIL timeout_recover: got acc=%0d done=%0d expected 1 6", acc, dc);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        int dc, ec, nx, un, pb, na, ps;
        logic a0, a1, bz;
        logic [31:0] d0, d1;
        int pulses;
        issue(16'd10, 16'd20, 16'd100, 16'd200, acc);
        repeat (5) @(negedge clk_i);
        #2 arst_ni = 1'b0;
        #1;
        asserts++;
        if ({apb_psel_o, apb_penable_o, apb_pwrite_o, apb_paddr_o, busy_o, done_o, err_o} !== 7'b0 ||
            apb_pwdata_o !== 32'h0 || cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL midreset_outputs: got psel=%b pen=%b pwr=%b paddr=%b pwdata=%h busy=%b done=%b err=%b rdy=%b",
                     apb_psel_o, apb_penable_o, apb_pwrite_o, apb_paddr_o, apb_pwdata_o, busy_o, done_o, err_o, cmd_ready_o);
        end
        @(negedge clk_i);
        arst_ni = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (done_o !== 1'b0 || err_o !== 1'b0 || cmd_ready_o !== 1'b1) pulses++;
        end
        asserts++;
        if (pulses !== 0) begin failures++; $display("FAIL midreset_quiet: got %0d bad cycles expected 0", pulses); end
        issue(16'd10, 16'd20, 16'd100, 16'd200, acc);
        watch(40, 0, 1'b0, 1'b0, dc, ec, nx, a0, d0, a1, d1, un, pb, na, bz, ps);
        asserts++;
        if (dc !== 6 || d0 !== 32'h0014000A || d1 !== 32'h00C80064) begin
            failures++; $display("FAIL midreset_fresh: got done=%0d %h %h expected 6 0014000a 00c80064", dc, d0, d1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait();
        test_invalid();
        test_slverr();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/roi_apb_master.md
ROI_APB_MASTER -- requirements
Module: roi_apb_master

Interface
REQ-001 Parameters SHALL be: WIDTH, 800, frame width in pixels; HEIGHT, 600, frame height in lines; BIT_C, 32, coordinate word width; TIMEOUT, 16, max ACCESS-phase wait cycles.
REQ-002 clk_i  input  1  single clock; all logic on rising edge.
REQ-003 arst_ni  input  1  reset; asynchronous assert, active-low.
REQ-004 cmd_valid_i  input  1  ROI command offered.
REQ-005 cmd_ready_o  output  1  command accepted when cmd_valid_i and cmd_ready_o are both high.
REQ-006 cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i  input  BIT_C/2 each  ROI corners.
REQ-007 apb_psel_o, apb_penable_o, apb_pwrite_o  output  1 each  APB requester controls.
REQ-008 apb_paddr_o  output  1  register select: 0 = xy_0, 1 = xy_1.
REQ-009 apb_pwdata_o  output  BIT_C  write data.
REQ-010 apb_pready_i, apb_pslverr_i  input  1 each  completer response.
REQ-011 busy_o  output  1  high from command accept until done/error.
REQ-012 done_o, err_o  output  1 each  one-cycle completion pulses, mutually exclusive.

Function
REQ-013 FSM states SHALL be IDLE, SETUP, ACCESS, NEXT, DONE, ERR.
REQ-014 IDLE: cmd_ready_o=1; on accept, register all four coordinates; if valid -> SETUP with index 0, else -> ERR; no APB activity.
REQ-015 Valid means x0<=x1, y0<=y1, x1<WIDTH, y1<HEIGHT, compared unsigned at BIT_C/2 bits.
REQ-016 Data word: index 0 = {y0,x0}, index 1 = {y1,x1}; y in upper BIT_C/2 bits.
REQ-017 SETUP (1 cycle): psel=1, penable=0, pwrite=1, paddr=index, pwdata=word[index] -> ACCESS.
REQ-018 ACCESS: psel=1, penable=1; paddr/pwdata/pwrite held stable since SETUP.
REQ-019 ACCESS with pready=1 and pslverr=0: index 0 -> NEXT; index 1 -> DONE.
REQ-020 ACCESS with pready=1 and pslverr=1 -> ERR; remaining transfer not issued.
REQ-021 Wait counter SHALL clear on SETUP entry and count ACCESS cycles with pready=0; reaching TIMEOUT -> ERR with psel/penable dropped next cycle.
REQ-022 NEXT (1 cycle): psel=0, penable=0, index<=1 -> SETUP; transfers are never back-to-back.
REQ-023 DONE: done_o=1 one cycle -> IDLE; ERR: err_o=1 one cycle -> IDLE.
REQ-024 Minimum latency accept -> done_o: 6 cycles with zero-wait completer (SETUP, ACCESS, NEXT, SETUP, ACCESS, DONE).
REQ-025 cmd_ready_o=0 in every state except IDLE; commands offered while busy are not accepted and not lost by the offerer's protocol.
REQ-026 psel=0 implies penable=0 always; pwrite=0 whenever psel=0.
REQ-027 pready/pslverr SHALL be ignored outside ACCESS.

Reset
REQ-028 arst_ni low SHALL force state IDLE, index 0, wait counter 0, coordinate registers 0 immediately.
REQ-029 Output reset values: cmd_ready_o=1 after release, busy_o=0, psel/penable/pwrite/paddr=0, pwdata=0, done_o=0, err_o=0.
REQ-030 Reset mid-transfer SHALL abort without done_o/err_o; the first cycle after release is IDLE.

Structure
REQ-031 Shared package roi_pkg SHALL hold the FSM state enum, address constants ADDR_XY0=0/ADDR_XY1=1, and the coordinate packing function.
REQ-032 No sub-module; validity check and packing are combinational within the block.

Verification
REQ-033 Cmd (10,20,100,200), pready tied 1 -> writes addr0 data 0x0014000A, addr1 data 0x00C80064, done_o 6 cycles after accept.
REQ-034 Same cmd, pready low 3 cycles in first ACCESS -> paddr/pwdata stable throughout, done_o 3 cycles later than REQ-033.
REQ-035 Cmd (0,0,800,10) -> no psel ever asserted, err_o one cycle after accept; also x0=50,x1=40 -> err_o.
REQ-036 pslverr=1 on first transfer -> err_o, no addr1 transfer, busy_o falls with err_o.
REQ-037 pready held 0 -> psel drops after 16 wait cycles, err_o pulses, next command accepted normally.
REQ-038 arst_ni asserted during second ACCESS -> all outputs at reset values same cycle, no done_o/err_o, fresh command completes.
